// File: rtl/majority_voter_seq.sv
// majority_voter_seq: registered N-input majority voter with configurable
// threshold, even-N tie-break, persistence filter on the voted output and a
// saturating dissent counter.
//
// Optional build macro: MAJ_VOTER_MASK_EN
//   When defined, adds the vote_mask input (1 = voter excluded). Masked votes
//   are forced to 0, the majority is judged against the active voter count,
//   and samples with no active voter leave the dissent counter untouched.
//   When undefined, all N voters are always active.
module majority_voter_seq #(
    parameter int unsigned N      = 4,
    parameter int unsigned THRESH = 0,
    parameter int unsigned HOLD   = 2,
    parameter int unsigned ERR_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [N-1:0]               votes,
`ifdef MAJ_VOTER_MASK_EN
    input  logic [N-1:0]               vote_mask,
`endif
    input  logic                       tie_val,
    input  logic                       clr_err,
    output logic                       out_valid,
    output logic [$clog2(N+1)-1:0]     count,
    output logic                       vote_raw,
    output logic                       vote_out,
    output logic [ERR_W-1:0]           dissent_cnt
);

    localparam int unsigned CW = $clog2(N+1);

    // Constants used by the default (strict majority) rule, sized to the
    // popcount width so every compare is unsigned at CW bits.
    localparam logic [CW-1:0] MAJ_T  = CW'(N / 2 + 1);
    localparam logic [CW-1:0] HALF_N = CW'(N / 2);
    localparam logic [CW-1:0] ALL_N  = CW'(N);
    localparam logic [CW-1:0] THR_C  = CW'(THRESH);
    localparam bit            N_EVEN = ((N % 2) == 0);

    // ------------------------------------------------------------------
    // Sample evaluation (combinational)
    // ------------------------------------------------------------------
    logic [N-1:0]  votes_eff;
    logic [CW-1:0] pc;          // popcount of the effective votes
    logic [CW-1:0] active;      // number of voters taking part
    logic          result;      // vote for this sample
    logic          unanimous;   // all active voters agree
    logic          dissent_inc; // sample counts as dissent

`ifdef MAJ_VOTER_MASK_EN
    logic [CW-1:0] mask_pc;
    logic [CW:0]   pc_x2;
    logic [CW:0]   active_x;

    // Apply the mask and derive the active voter count.
    always_comb begin
        votes_eff = votes & ~vote_mask;
        mask_pc   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            mask_pc = mask_pc + CW'(vote_mask[i]);
        end
        active = ALL_N - mask_pc;
    end
`else
    // All voters active; the effective votes are the raw inputs.
    always_comb begin
        votes_eff = votes;
        active    = ALL_N;
    end
`endif

    // Popcount of the effective votes at CW bits.
    always_comb begin
        pc = '0;
        for (int unsigned i = 0; i < N; i++) begin
            pc = pc + CW'(votes_eff[i]);
        end
    end

    // Threshold / majority decision for the current sample.
    always_comb begin
        result = 1'b0;
`ifdef MAJ_VOTER_MASK_EN
        pc_x2    = {pc, 1'b0};
        active_x = {1'b0, active};
        if (active == '0) begin
            result = 1'b0;
        end else if (THRESH != 0) begin
            result = (pc >= THR_C);
        end else if (pc_x2 > active_x) begin
            result = 1'b1;
        end else if (pc_x2 == active_x) begin
            result = tie_val;
        end else begin
            result = 1'b0;
        end
`else
        if (THRESH != 0) begin
            result = (pc >= THR_C);
        end else if (N_EVEN && (pc == HALF_N)) begin
            result = tie_val;
        end else begin
            result = (pc >= MAJ_T);
        end
`endif
    end

    // Unanimity is judged against the active voter count; an empty voter
    // set never counts as dissent.
    always_comb begin
        unanimous   = (pc == '0) || (pc == active);
        dissent_inc = in_valid && !unanimous && (active != '0);
    end

    // ------------------------------------------------------------------
    // Stage 1: registered valid, popcount and raw vote
    // ------------------------------------------------------------------
    logic          valid_q, valid_d;
    logic [CW-1:0] count_q, count_d;
    logic          raw_q,   raw_d;

    // Next-state for stage 1: count and raw vote hold on idle cycles.
    always_comb begin
        valid_d = in_valid;
        count_d = count_q;
        raw_d   = raw_q;
        if (in_valid) begin
            count_d = pc;
            raw_d   = result;
        end
    end

    // Stage 1 registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            count_q <= '0;
            raw_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            raw_q   <= raw_d;
        end
    end

    assign out_valid = valid_q;
    assign count     = count_q;
    assign vote_raw  = raw_q;

    // ------------------------------------------------------------------
    // Persistence filter on the voted output
    // ------------------------------------------------------------------
    generate
        if (HOLD == 0) begin : g_bypass
            assign vote_out = raw_q;
        end else begin : g_filter
            localparam int unsigned FW = (HOLD > 1) ? $clog2(HOLD) : 1;
            localparam logic [FW-1:0] LAST = FW'(HOLD - 1);

            logic [FW-1:0] flt_q, flt_d;
            logic          out_q, out_d;

            // Count consecutive valid samples that disagree with the
            // current output; any agreeing sample restarts the count.
            always_comb begin
                flt_d = flt_q;
                out_d = out_q;
                if (valid_q) begin
                    if (raw_q == out_q) begin
                        flt_d = '0;
                    end else if (flt_q == LAST) begin
                        out_d = raw_q;
                        flt_d = '0;
                    end else begin
                        flt_d = flt_q + FW'(1);
                    end
                end
            end

            // Filter registers; reset discards any partial progress.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    flt_q <= '0;
                    out_q <= 1'b0;
                end else begin
                    flt_q <= flt_d;
                    out_q <= out_d;
                end
            end

            assign vote_out = out_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Saturating dissent counter
    // ------------------------------------------------------------------
    logic [ERR_W-1:0] dissent_q, dissent_d;

    // Clear has priority over a simultaneous increment; no wrap at the top.
    always_comb begin
        dissent_d = dissent_q;
        if (clr_err) begin
            dissent_d = '0;
        end else if (dissent_inc && (dissent_q != '1)) begin
            dissent_d = dissent_q + ERR_W'(1);
        end
    end

    // Dissent counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dissent_q <= '0;
        end else begin
            dissent_q <= dissent_d;
        end
    end

    assign dissent_cnt = dissent_q;

endmodule

// File: tb/tb_majority_voter_seq.sv
// Directed bench for majority_voter_seq (N=4, HOLD=2, THRESH=0, ERR_W=2).
module tb_majority_voter_seq;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] votes;
    logic       tie_val;
    logic       clr_err;
    logic       out_valid;
    logic [2:0] count;
    logic       vote_raw;
    logic       vote_out;
    logic [1:0] dissent_cnt;

    int passed;
    int total;

    majority_voter_seq #(
        .N      (4),
        .THRESH (0),
        .HOLD   (2),
        .ERR_W  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .votes       (votes),
        .tie_val     (tie_val),
        .clr_err     (clr_err),
        .out_valid   (out_valid),
        .count       (count),
        .vote_raw    (vote_raw),
        .vote_out    (vote_out),
        .dissent_cnt (dissent_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [3:0] vt;
        logic       tie;
        logic       clr;
        logic       ev;
        logic [2:0] ec;
        logic       er;
        logic       eo;
        logic [1:0] ed;
    } vec_t;

    vec_t tbl[19];

    task automatic check(input string name, input int idx, input int act, input int exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic ev, input logic [2:0] ec,
                             input logic er, input logic eo, input logic [1:0] ed);
        check("out_valid",   idx, int'(out_valid),   int'(ev));
        check("count",       idx, int'(count),       int'(ec));
        check("vote_raw",    idx, int'(vote_raw),    int'(er));
        check("vote_out",    idx, int'(vote_out),    int'(eo));
        check("dissent_cnt", idx, int'(dissent_cnt), int'(ed));
    endtask

    // Drive inputs away from the active edge, then sample just after it.
    task automatic drive(input logic v, input logic [3:0] vt, input logic tie, input logic clr);
        @(negedge clk);
        in_valid = v;
        votes    = vt;
        tie_val  = tie;
        clr_err  = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        passed   = 0;
        total    = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        votes    = 4'b0000;
        tie_val  = 1'b0;
        clr_err  = 1'b0;

        //            v  votes    tie   clr   ev  ec   er  eo  ed
        tbl[0]  = '{1'b1, 4'b1110, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 2'd1};
        tbl[1]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 2'd1};
        tbl[2]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 2'd1};
        tbl[3]  = '{1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 2'd2};
        tbl[4]  = '{1'b1, 4'b1110, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 2'd3};
        tbl[5]  = '{1'b1, 4'b1110, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 2'd3};
        tbl[6]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 2'd3};
        tbl[7]  = '{1'b1, 4'b1100, 1'b1, 1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 2'd0};
        tbl[8]  = '{1'b1, 4'b1100, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 2'd1};
        tbl[9]  = '{1'b1, 4'b1111, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b1, 2'd1};
        tbl[10] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 2'd1};
        tbl[11] = '{1'b1, 4'b1111, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b1, 2'd1};
        tbl[12] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 2'd1};
        tbl[13] = '{1'b1, 4'b1111, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b1, 2'd1};
        tbl[14] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 2'd1};
        tbl[15] = '{1'b1, 4'b0111, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 2'd2};
        tbl[16] = '{1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 2'd3};
        tbl[17] = '{1'b1, 4'b0011, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 2'd3};
        tbl[18] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 2'd0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all(100, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0);
        rst = 1'b0;

        // Table-driven sequence
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].v, tbl[i].vt, tbl[i].tie, tbl[i].clr);
            check_all(i, tbl[i].ev, tbl[i].ec, tbl[i].er, tbl[i].eo, tbl[i].ed);
        end

        // Async reset with vote_out=1 and dissent_cnt=2, no clock edge
        drive(1'b1, 4'b0111, 1'b0, 1'b0);
        drive(1'b1, 4'b0111, 1'b0, 1'b0);
        drive(1'b0, 4'b0000, 1'b0, 1'b0);
        check_all(200, 1'b0, 3'd3, 1'b1, 1'b1, 2'd2);
        #2 rst = 1'b1;
        #1;
        check_all(201, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0);
        rst = 1'b0;

        // Reset mid-filter must discard the partial count
        drive(1'b1, 4'b1110, 1'b0, 1'b0);
        drive(1'b0, 4'b0000, 1'b0, 1'b0);
        check_all(300, 1'b0, 3'd3, 1'b1, 1'b0, 2'd1);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        drive(1'b1, 4'b1110, 1'b0, 1'b0);
        drive(1'b0, 4'b0000, 1'b0, 1'b0);
        check_all(301, 1'b0, 3'd3, 1'b1, 1'b0, 2'd1);
        drive(1'b0, 4'b0000, 1'b0, 1'b0);
        check_all(302, 1'b0, 3'd3, 1'b1, 1'b0, 2'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
